// File: rtl/issue_age_select_if.sv
// issue_age_select_if: alloc/select bus between an issue queue and its age-ordered select scheduler
interface issue_age_select_if #(
   parameter int QUEUE_LEN = 8,
   parameter int WRITE_NUM = 2,
   parameter int READ_NUM  = 1
) ();
   localparam int IDXW = $clog2(QUEUE_LEN);
   logic                      flush;
   logic [WRITE_NUM-1:0]      alloc_req;
   logic [WRITE_NUM*IDXW-1:0] alloc_idx;
   logic [QUEUE_LEN-1:0]      ready;
   logic [READ_NUM-1:0]       grant_valid;
   logic [READ_NUM*IDXW-1:0]  grant_idx;
   logic [QUEUE_LEN-1:0]      grant_onehot;
   logic [QUEUE_LEN-1:0]      occupied;
   logic [IDXW:0]             count;
   logic                      full;
   modport master (output flush, alloc_req, ready,
                   input  alloc_idx, grant_valid, grant_idx, grant_onehot, occupied, count, full);
   modport slave  (input  flush, alloc_req, ready,
                   output alloc_idx, grant_valid, grant_idx, grant_onehot, occupied, count, full);
endinterface

// File: rtl/issue_age_select.sv
// issue_age_select: age-matrix select scheduler for one issue queue; ISSUE_SELECT_HOLD_EN adds a hold port that suppresses grants
module issue_age_select #(
   parameter int QUEUE_LEN = 8,
   parameter int WRITE_NUM = 2,
   parameter int READ_NUM  = 1
) (
   input logic clk,
   input logic resetn,
`ifdef ISSUE_SELECT_HOLD_EN
   input logic hold,
`endif
   issue_age_select_if.slave bus
);
   localparam int IDXW = $clog2(QUEUE_LEN);
   logic [QUEUE_LEN-1:0]                 valid, nxt_valid, cand, rem, freed, avail, alloc_set, stay;
   logic [QUEUE_LEN-1:0][QUEUE_LEN-1:0]  older, nxt_older;
   logic [QUEUE_LEN-1:0]                 win [READ_NUM];
   logic [WRITE_NUM-1:0][IDXW-1:0]       slot;
   logic [WRITE_NUM-1:0]                 slot_ok, alloc_en;
   logic [IDXW:0]                        cnt;
   logic                                 full_w, sup;

   function automatic logic [QUEUE_LEN-1:0] oldest(input logic [QUEUE_LEN-1:0] c,
                                                   input logic [QUEUE_LEN-1:0][QUEUE_LEN-1:0] o);
      oldest = '0;
      for (int i = 0; i < QUEUE_LEN; i++) begin
         oldest[i] = c[i];
         for (int j = 0; j < QUEUE_LEN; j++) if (c[j] && o[j][i]) oldest[i] = 1'b0;
      end
   endfunction

`ifdef ISSUE_SELECT_HOLD_EN
   assign sup = bus.flush | hold;
`else
   assign sup = bus.flush;
`endif
   assign cand     = valid & bus.ready & {QUEUE_LEN{~sup}};
   assign full_w   = int'(cnt) > QUEUE_LEN - WRITE_NUM;
   assign alloc_en = bus.alloc_req & slot_ok & {WRITE_NUM{~full_w}};
   assign bus.full         = full_w;
   assign bus.count        = cnt;
   assign bus.occupied     = valid;
   assign bus.grant_onehot = freed;
   assign bus.alloc_idx    = slot;

   // Each port takes the oldest remaining candidate, then hides it from the next port
   always_comb begin
      rem   = cand;
      freed = '0;
      for (int g = 0; g < READ_NUM; g++) begin
         win[g] = oldest(rem, older);
         rem    = rem & ~win[g];
         freed  = freed | win[g];
      end
   end

   // Encode per-port winners; an empty port reports index 0
   always_comb begin
      bus.grant_valid = '0;
      bus.grant_idx   = '0;
      for (int g = 0; g < READ_NUM; g++) begin
         bus.grant_valid[g] = |win[g];
         for (int i = 0; i < QUEUE_LEN; i++) if (win[g][i]) bus.grant_idx[g*IDXW +: IDXW] = IDXW'(i);
      end
   end

   // Offer lowest-index free slots in lane order, from registered occupancy only
   always_comb begin
      avail   = ~valid;
      slot    = '0;
      slot_ok = '0;
      for (int l = 0; l < WRITE_NUM; l++) begin
         for (int i = QUEUE_LEN - 1; i >= 0; i--) if (avail[i]) begin
            slot[l]    = IDXW'(i);
            slot_ok[l] = 1'b1;
         end
         if (slot_ok[l]) avail[slot[l]] = 1'b0;
      end
   end

   // Occupancy count
   always_comb begin
      cnt = '0;
      for (int i = 0; i < QUEUE_LEN; i++) cnt = cnt + (IDXW+1)'(valid[i]);
   end

   // Next age matrix: survivors become older than new slots, lower lanes older than higher lanes
   always_comb begin
      alloc_set = '0;
      for (int l = 0; l < WRITE_NUM; l++) if (alloc_en[l]) alloc_set[slot[l]] = 1'b1;
      stay      = valid & ~freed;
      nxt_valid = stay | alloc_set;
      nxt_older = '0;
      for (int i = 0; i < QUEUE_LEN; i++)
         for (int j = 0; j < QUEUE_LEN; j++)
            nxt_older[i][j] = stay[i] & ((stay[j] & older[i][j]) | alloc_set[j]);
      for (int a = 0; a < WRITE_NUM; a++)
         for (int b = a + 1; b < WRITE_NUM; b++)
            if (alloc_en[a] && alloc_en[b]) nxt_older[slot[a]][slot[b]] = 1'b1;
   end

   // State update; flush wipes everything regardless of same-cycle alloc or grant
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         valid <= '0;
         older <= '0;
      end else if (bus.flush) begin
         valid <= '0;
         older <= '0;
      end else begin
         valid <= nxt_valid;
         older <= nxt_older;
      end
   end

   // Age matrix must stay a strict total order over valid entries
   always @(posedge clk) begin
      if (resetn)
         for (int i = 0; i < QUEUE_LEN; i++)
            for (int j = 0; j < QUEUE_LEN; j++)
               assert (i == j ? !older[i][i] : (!(valid[i] && valid[j]) || (older[i][j] ^ older[j][i])));
   end
endmodule

// File: tb/tb_issue_age_select.sv
// tb_issue_age_select: random + directed bench for READ_NUM=1 and READ_NUM=2 schedulers against an allocation-stamp model
module tb_issue_age_select;
   localparam int Q = 8, W = 2;
   logic clk, resetn, flush, hold;
   logic [1:0] req;
   logic [7:0] rdy;
   int checks = 0, fails = 0, seq = 0;

   issue_age_select_if #(.QUEUE_LEN(Q), .WRITE_NUM(W), .READ_NUM(1)) b1 ();
   issue_age_select_if #(.QUEUE_LEN(Q), .WRITE_NUM(W), .READ_NUM(2)) b2 ();
   assign b1.flush = flush; assign b1.alloc_req = req; assign b1.ready = rdy;
   assign b2.flush = flush; assign b2.alloc_req = req; assign b2.ready = rdy;

   issue_age_select #(.QUEUE_LEN(Q), .WRITE_NUM(W), .READ_NUM(1)) u1 (
      .clk(clk), .resetn(resetn),
`ifdef ISSUE_SELECT_HOLD_EN
      .hold(hold),
`endif
      .bus(b1));
   issue_age_select #(.QUEUE_LEN(Q), .WRITE_NUM(W), .READ_NUM(2)) u2 (
      .clk(clk), .resetn(resetn),
`ifdef ISSUE_SELECT_HOLD_EN
      .hold(hold),
`endif
      .bus(b2));

   logic [1:0] o_gv [2];
   logic [2:0] o_gi [2][2];
   logic [2:0] o_ai [2][2];
   logic [7:0] o_oh [2], o_occ [2];
   logic [3:0] o_cnt [2];
   logic       o_full [2];
   assign o_gv[0] = {1'b0, b1.grant_valid};  assign o_gv[1] = b2.grant_valid;
   assign o_gi[0][0] = b1.grant_idx;         assign o_gi[0][1] = 3'd0;
   assign o_gi[1][0] = b2.grant_idx[2:0];    assign o_gi[1][1] = b2.grant_idx[5:3];
   assign o_ai[0][0] = b1.alloc_idx[2:0];    assign o_ai[0][1] = b1.alloc_idx[5:3];
   assign o_ai[1][0] = b2.alloc_idx[2:0];    assign o_ai[1][1] = b2.alloc_idx[5:3];
   assign o_oh[0] = b1.grant_onehot;  assign o_oh[1] = b2.grant_onehot;
   assign o_occ[0] = b1.occupied;     assign o_occ[1] = b2.occupied;
   assign o_cnt[0] = b1.count;        assign o_cnt[1] = b2.count;
   assign o_full[0] = b1.full;        assign o_full[1] = b2.full;

   // model: each valid slot carries the sequence number of its allocation; smaller = older
   logic [7:0] m_valid [2];
   int         m_stamp [2][8];
   int         rn [2] = '{1, 2};
   logic [1:0] e_gv [2];
   logic [2:0] e_gi [2][2];
   logic [2:0] e_ai [2][2];
   logic [7:0] e_oh [2], e_occ [2];
   logic [3:0] e_cnt [2];
   logic       e_full [2];
   int         e_nfree [2];

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   task automatic predict();
      for (int d = 0; d < 2; d++) begin
         int best;
         e_occ[d] = m_valid[d];
         e_cnt[d] = 4'($countones(m_valid[d]));
         e_full[d] = $countones(m_valid[d]) > Q - W;
         e_nfree[d] = 0;
         e_ai[d][0] = 0; e_ai[d][1] = 0;
         for (int i = 0; i < Q; i++)
            if (!m_valid[d][i] && e_nfree[d] < W) begin
               e_ai[d][e_nfree[d]] = 3'(i);
               e_nfree[d]++;
            end
         e_gv[d] = 0; e_gi[d][0] = 0; e_gi[d][1] = 0; e_oh[d] = 0;
         if (!(flush || hold))
            for (int g = 0; g < rn[d]; g++) begin
               best = -1;
               for (int i = 0; i < Q; i++)
                  if (m_valid[d][i] && rdy[i] && !e_oh[d][i] && (best < 0 || m_stamp[d][i] < m_stamp[d][best])) best = i;
               if (best >= 0) begin
                  e_gv[d][g] = 1'b1;
                  e_gi[d][g] = 3'(best);
                  e_oh[d][best] = 1'b1;
               end
            end
      end
   endtask

   task automatic commit();
      for (int d = 0; d < 2; d++)
         if (flush) m_valid[d] = 0;
         else begin
            m_valid[d] = m_valid[d] & ~e_oh[d];
            if (!e_full[d])
               for (int l = 0; l < W; l++)
                  if (req[l]) begin
                     m_valid[d][e_ai[d][l]] = 1'b1;
                     m_stamp[d][e_ai[d][l]] = seq++;
                  end
         end
   endtask

   task automatic drive(input logic f, input logic [1:0] r, input logic [7:0] rd, input logic h);
      flush = f; req = r; rdy = rd; hold = h;
      @(negedge clk);
      predict();
   endtask

   task automatic advance();
      commit();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      resetn = 0; flush = 0; req = 2'b11; rdy = 8'hff; hold = 0;
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         checks++; if (o_gv[d] !== 0) begin fails++; $display("FAIL reset_gv d%0d got %b exp 0", d, o_gv[d]); end
         checks++; if (o_oh[d] !== 0) begin fails++; $display("FAIL reset_onehot d%0d got %b exp 0", d, o_oh[d]); end
         checks++; if (o_occ[d] !== 0) begin fails++; $display("FAIL reset_occ d%0d got %b exp 0", d, o_occ[d]); end
         checks++; if (o_cnt[d] !== 0 || o_full[d] !== 0) begin fails++; $display("FAIL reset_cnt_full d%0d got %0d/%b exp 0/0", d, o_cnt[d], o_full[d]); end
         checks++; if (o_ai[d][0] !== 0 || o_ai[d][1] !== 1) begin fails++; $display("FAIL reset_alloc_idx d%0d got %0d,%0d exp 0,1", d, o_ai[d][0], o_ai[d][1]); end
      end
      @(posedge clk); #1;
      resetn = 1; req = 0; rdy = 0;
      m_valid[0] = 0; m_valid[1] = 0;
   endtask

   task automatic test_alloc();
      drive(0, 2'b11, 0, 0);
      for (int d = 0; d < 2; d++) begin
         checks++; if (o_ai[d][0] !== 0 || o_ai[d][1] !== 1) begin fails++; $display("FAIL alloc_first_idx d%0d got %0d,%0d exp 0,1", d, o_ai[d][0], o_ai[d][1]); end
      end
      advance();
      drive(0, 0, 0, 0);
      for (int d = 0; d < 2; d++) begin
         checks++; if (o_occ[d] !== 8'b11 || o_cnt[d] !== 2) begin fails++; $display("FAIL alloc_occ d%0d got %b/%0d exp 00000011/2", d, o_occ[d], o_cnt[d]); end
         checks++; if (o_gv[d] !== 0) begin fails++; $display("FAIL alloc_no_grant d%0d got %b exp 0", d, o_gv[d]); end
         checks++; if (o_ai[d][0] !== 2 || o_ai[d][1] !== 3) begin fails++; $display("FAIL alloc_next_idx d%0d got %0d,%0d exp 2,3", d, o_ai[d][0], o_ai[d][1]); end
      end
      advance();
      drive(1, 0, 0, 0); advance();
   endtask

   task automatic test_age_order();
      repeat (3) begin drive(0, 2'b01, 0, 0); advance(); end
      drive(0, 0, 8'b0000_0110, 0);
      checks++; if (o_gv[0] !== 2'b01 || o_gi[0][0] !== 1) begin fails++; $display("FAIL age_r1_first got v=%b idx=%0d exp v=01 idx=1", o_gv[0], o_gi[0][0]); end
      checks++; if (o_gi[1][0] !== 1 || o_gi[1][1] !== 2 || o_gv[1] !== 2'b11) begin fails++; $display("FAIL age_r2_pair got %0d,%0d v=%b exp 1,2 v=11", o_gi[1][0], o_gi[1][1], o_gv[1]); end
      checks++; if (o_oh[1] !== 8'b0000_0110) begin fails++; $display("FAIL age_r2_onehot got %b exp 00000110", o_oh[1]); end
      advance();
      drive(0, 0, 8'b0000_0100, 0);
      checks++; if (o_gv[0] !== 2'b01 || o_gi[0][0] !== 2) begin fails++; $display("FAIL age_r1_second got v=%b idx=%0d exp v=01 idx=2", o_gv[0], o_gi[0][0]); end
      checks++; if (o_gv[1] !== 0 || o_gi[1][0] !== 0) begin fails++; $display("FAIL age_r2_freed got v=%b idx=%0d exp v=00 idx=0", o_gv[1], o_gi[1][0]); end
      advance();
      drive(1, 0, 0, 0); advance();
   endtask

   task automatic test_full();
      repeat (3) begin drive(0, 2'b11, 0, 0); advance(); end
      drive(0, 2'b01, 0, 0); advance();
      drive(0, 2'b11, 0, 0);
      for (int d = 0; d < 2; d++) begin
         checks++; if (o_cnt[d] !== 7 || o_full[d] !== 1) begin fails++; $display("FAIL full_set d%0d got %0d/%b exp 7/1", d, o_cnt[d], o_full[d]); end
      end
      advance();
      drive(0, 0, 8'b0000_0001, 0);
      for (int d = 0; d < 2; d++) begin
         checks++; if (o_cnt[d] !== 7 || o_full[d] !== 1) begin fails++; $display("FAIL full_ignores_req d%0d got %0d/%b exp 7/1", d, o_cnt[d], o_full[d]); end
         checks++; if (o_gv[d] !== 2'b01 || o_gi[d][0] !== 0) begin fails++; $display("FAIL full_grant d%0d got v=%b idx=%0d exp v=01 idx=0", d, o_gv[d], o_gi[d][0]); end
      end
      advance();
      drive(0, 0, 0, 0);
      for (int d = 0; d < 2; d++) begin
         checks++; if (o_cnt[d] !== 6 || o_full[d] !== 0) begin fails++; $display("FAIL full_clear d%0d got %0d/%b exp 6/0", d, o_cnt[d], o_full[d]); end
      end
      advance();
      drive(1, 0, 0, 0); advance();
   endtask

   task automatic test_two_ports();
      repeat (3) begin drive(0, 2'b11, 0, 0); advance(); end
      repeat (2) begin drive(0, 0, 8'b0001_0111, 0); advance(); end
      drive(0, 2'b01, 0, 0); advance();
      drive(0, 0, 8'hff, 0);
      checks++; if (o_occ[1] !== 8'b0010_1001) begin fails++; $display("FAIL ports_occ got %b exp 00101001", o_occ[1]); end
      checks++; if (o_gv[1] !== 2'b11 || o_gi[1][0] !== 3 || o_gi[1][1] !== 5) begin fails++; $display("FAIL ports_pair got %0d,%0d v=%b exp 3,5 v=11", o_gi[1][0], o_gi[1][1], o_gv[1]); end
      advance();
      drive(0, 0, 8'hff, 0);
      checks++; if (o_gv[1] !== 2'b01 || o_gi[1][0] !== 0 || o_gi[1][1] !== 0) begin fails++; $display("FAIL ports_last got %0d,%0d v=%b exp 0,0 v=01", o_gi[1][0], o_gi[1][1], o_gv[1]); end
      checks++; if (o_gi[0] != e_gi[0] || o_gv[0] !== e_gv[0]) begin fails++; $display("FAIL ports_r1 got %0d v=%b exp %0d v=%b", o_gi[0][0], o_gv[0], e_gi[0][0], e_gv[0]); end
      advance();
      drive(1, 0, 0, 0); advance();
   endtask

   task automatic test_flush();
      drive(0, 2'b11, 0, 0); advance();
      drive(1, 2'b11, 8'hff, 0);
      for (int d = 0; d < 2; d++) begin
         checks++; if (o_gv[d] !== 0 || o_oh[d] !== 0) begin fails++; $display("FAIL flush_grant d%0d got v=%b oh=%b exp 0/0", d, o_gv[d], o_oh[d]); end
      end
      advance();
      drive(0, 0, 0, 0);
      for (int d = 0; d < 2; d++) begin
         checks++; if (o_cnt[d] !== 0 || o_occ[d] !== 0) begin fails++; $display("FAIL flush_empty d%0d got %0d/%b exp 0/0", d, o_cnt[d], o_occ[d]); end
      end
      advance();
   endtask

`ifdef ISSUE_SELECT_HOLD_EN
   task automatic test_hold();
      drive(0, 2'b11, 0, 0); advance();
      drive(0, 0, 8'hff, 1);
      for (int d = 0; d < 2; d++) begin
         checks++; if (o_gv[d] !== 0 || o_oh[d] !== 0) begin fails++; $display("FAIL hold_grant d%0d got v=%b oh=%b exp 0/0", d, o_gv[d], o_oh[d]); end
      end
      advance();
      drive(0, 0, 8'hff, 0);
      for (int d = 0; d < 2; d++) begin
         checks++; if (o_occ[d] !== 8'b11) begin fails++; $display("FAIL hold_retain d%0d got %b exp 00000011", d, o_occ[d]); end
         checks++; if (o_gv[d][0] !== 1 || o_gi[d][0] !== 0) begin fails++; $display("FAIL hold_release d%0d got v=%b idx=%0d exp v=1 idx=0", d, o_gv[d][0], o_gi[d][0]); end
      end
      advance();
      drive(1, 0, 0, 0); advance();
   endtask
`endif

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         logic h;
         h = 0;
`ifdef ISSUE_SELECT_HOLD_EN
         h = ($urandom % 8) == 0;
`endif
         drive(($urandom % 25) == 0, 2'($urandom), 8'($urandom), h);
         for (int d = 0; d < 2; d++) begin
            checks++; if (o_gv[d] !== e_gv[d] || o_gi[d][0] !== e_gi[d][0] || o_gi[d][1] !== e_gi[d][1]) begin fails++; $display("FAIL rnd_grant d%0d cyc%0d got v=%b %0d,%0d exp v=%b %0d,%0d", d, n, o_gv[d], o_gi[d][0], o_gi[d][1], e_gv[d], e_gi[d][0], e_gi[d][1]); end
            checks++; if (o_oh[d] !== e_oh[d]) begin fails++; $display("FAIL rnd_onehot d%0d cyc%0d got %b exp %b", d, n, o_oh[d], e_oh[d]); end
            checks++; if (o_occ[d] !== e_occ[d] || o_cnt[d] !== e_cnt[d] || o_full[d] !== e_full[d]) begin fails++; $display("FAIL rnd_occ d%0d cyc%0d got %b/%0d/%b exp %b/%0d/%b", d, n, o_occ[d], o_cnt[d], o_full[d], e_occ[d], e_cnt[d], e_full[d]); end
            for (int l = 0; l < W; l++)
               if (l < e_nfree[d]) begin
                  checks++; if (o_ai[d][l] !== e_ai[d][l]) begin fails++; $display("FAIL rnd_alloc_idx d%0d cyc%0d lane%0d got %0d exp %0d", d, n, l, o_ai[d][l], e_ai[d][l]); end
               end
         end
         advance();
      end
   endtask

   initial begin
      test_reset();
      test_alloc();
      test_age_order();
      test_full();
      test_two_ports();
      test_flush();
`ifdef ISSUE_SELECT_HOLD_EN
      test_hold();
`endif
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
